sdram_responder: RTL and testbench

SDRAM_RESPONDER -- requirements
Module: sdram_responder

---
 rtl/sdram_responder.sv | 269 ++++++++++++++++++++++++++
 tb/tb_sdram_responder.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_responder.sv
// sdram_responder: behavioural SDR SDRAM device model that checks controller command sequences.
// Defining SDRAM_RESPONDER_TIMING_CHK_EN adds tRCD/tRP/tRFC violation flagging on err[3].
module sdram_responder #(
    parameter int MEM_ROW_BITS = 2,
    parameter int T_RCD        = 2,
    parameter int T_RP         = 2,
    parameter int T_RFC        = 7
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        sdram_cke,
    input  logic        sdram_cs_n,
    input  logic        sdram_ras_n,
    input  logic        sdram_cas_n,
    input  logic        sdram_we_n,
    input  logic [1:0]  sdram_bank,
    input  logic [11:0] sdram_addr,
    input  logic [1:0]  sdram_dqm,
    input  logic [15:0] sdram_dq_in,
    output logic [15:0] sdram_dq_out,
    output logic [1:0]  sdram_dq_oe,
    output logic        mode_valid,
    output logic [3:0]  err
);
    localparam int AW = 11 + MEM_ROW_BITS;

    typedef enum logic [2:0] {
        CMD_LMR = 3'b000, CMD_REF = 3'b001, CMD_PRE = 3'b010, CMD_ACT = 3'b011,
        CMD_WR  = 3'b100, CMD_RD  = 3'b101, CMD_BST = 3'b110, CMD_NOP = 3'b111
    } cmd_e;
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_READ = 2'd1, ST_WRITE = 2'd2} state_e;

    logic [15:0] mem [0:(1 << AW) - 1];

    state_e             state_q, state_d;
    logic [2:0]         beats_q, beats_d, mask_q, mask_d, bl_mask_q, bl_mask_d;
    logic [8:0]         col_q, col_d;
    logic [1:0]         bbank_q, bbank_d;
    logic               ap_q, ap_d, cl3_q, cl3_d, mode_valid_q, mode_valid_d;
    logic [3:0]         open_q, open_d, err_q, err_d;
    logic [3:0][11:0]   row_q, row_d;
    logic [2:0]         pipe_v_q, pipe_v_d;
    logic [2:0][15:0]   pipe_data_q, pipe_data_d;
    logic [1:0]         dqm1_q, dqm1_d, dqm2_q, dqm2_d, dq_oe_q, dq_oe_d;
    logic [15:0]        dq_out_q, dq_out_d;

    cmd_e        cmd_s;
    logic        rw_ok_s, beat_v_s, beat_wr_s, mem_we_s, dq_hit_s, tchk_err_s;
    logic [1:0]  beat_bank_s, mem_be_s;
    logic [8:0]  beat_col_s;
    logic [AW-1:0] mem_idx_s;
    logic [15:0] dq_word_s;

    function automatic logic [8:0] next_col(input logic [8:0] col, input logic [2:0] mask);
        logic [8:0] m;
        m = {6'b000000, mask};
        return (col & ~m) | ((col + 9'd1) & m);
    endfunction

    assign cmd_s     = sdram_cs_n ? CMD_NOP : cmd_e'({sdram_ras_n, sdram_cas_n, sdram_we_n});
    assign rw_ok_s   = mode_valid_q && open_q[sdram_bank];
    assign dq_hit_s  = cl3_q ? pipe_v_q[2] : pipe_v_q[1];
    assign dq_word_s = cl3_q ? pipe_data_q[2] : pipe_data_q[1];

`ifdef SDRAM_RESPONDER_TIMING_CHK_EN
    localparam logic [7:0] RCD_L = 8'(T_RCD);
    localparam logic [7:0] RP_L  = 8'(T_RP);
    localparam logic [7:0] RFC_L = 8'(T_RFC);
    logic [3:0][7:0] rcd_q, rcd_d, rp_q, rp_d;
    logic [7:0]      rfc_q, rfc_d;

    // Saturating cycles-since-event counters; a value of 1 means the event was last cycle.
    always_comb begin
        rcd_d = rcd_q;
        rp_d = rp_q;
        rfc_d = rfc_q;
        tchk_err_s = 1'b0;
        if (sdram_cke) begin
            for (int b = 0; b < 4; b++) begin
                rcd_d[b] = (rcd_q[b] != 8'hFF) ? rcd_q[b] + 8'd1 : rcd_q[b];
                rp_d[b]  = (rp_q[b] != 8'hFF) ? rp_q[b] + 8'd1 : rp_q[b];
            end
            rfc_d = (rfc_q != 8'hFF) ? rfc_q + 8'd1 : rfc_q;
            tchk_err_s = (cmd_s != CMD_NOP) && (rfc_q < RFC_L);
            case (cmd_s)
                CMD_ACT: begin
                    if (rp_q[sdram_bank] < RP_L) tchk_err_s = 1'b1;
                    else tchk_err_s = tchk_err_s;
                    if (!open_q[sdram_bank]) rcd_d[sdram_bank] = 8'd1;
                    else rcd_d[sdram_bank] = rcd_d[sdram_bank];
                end
                CMD_RD, CMD_WR: begin
                    if (rcd_q[sdram_bank] < RCD_L) tchk_err_s = 1'b1;
                    else tchk_err_s = tchk_err_s;
                end
                CMD_PRE: begin
                    if (sdram_addr[10]) rp_d = {4{8'd1}};
                    else rp_d[sdram_bank] = 8'd1;
                end
                CMD_REF: rfc_d = 8'd1;
                default: rfc_d = rfc_d;
            endcase
        end else begin
            tchk_err_s = 1'b0;
        end
    end

    // Timing counter state.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rcd_q <= {4{8'hFF}};
            rp_q  <= {4{8'hFF}};
            rfc_q <= 8'hFF;
        end else begin
            rcd_q <= rcd_d;
            rp_q  <= rp_d;
            rfc_q <= rfc_d;
        end
    end
`else
    assign tchk_err_s = 1'b0;
`endif

    // Command decode, burst sequencing, read pipeline and output staging.
    always_comb begin
        state_d = state_q;         beats_d = beats_q;       mask_d = mask_q;
        bl_mask_d = bl_mask_q;     col_d = col_q;           bbank_d = bbank_q;
        ap_d = ap_q;               cl3_d = cl3_q;           mode_valid_d = mode_valid_q;
        open_d = open_q;           row_d = row_q;           err_d = err_q;
        pipe_v_d = pipe_v_q;       pipe_data_d = pipe_data_q;
        dqm1_d = dqm1_q;           dqm2_d = dqm2_q;
        dq_oe_d = dq_oe_q;         dq_out_d = dq_out_q;
        beat_v_s = 1'b0;           beat_wr_s = 1'b0;
        beat_bank_s = bbank_q;     beat_col_s = col_q;
        if (sdram_cke) begin
            dqm1_d = sdram_dqm;
            dqm2_d = dqm1_q;
            pipe_v_d = {pipe_v_q[1:0], 1'b0};
            pipe_data_d = {pipe_data_q[1:0], 16'h0000};
            dq_oe_d = {2{dq_hit_s}} & ~dqm2_q;
            dq_out_d = {dq_oe_d[1] ? dq_word_s[15:8] : 8'h00, dq_oe_d[0] ? dq_word_s[7:0] : 8'h00};
            // A valid new access or BURST STOP pre-empts the running burst.
            if (state_q != ST_IDLE) begin
                if (((cmd_s == CMD_RD || cmd_s == CMD_WR) && rw_ok_s) || cmd_s == CMD_BST) begin
                    state_d = ST_IDLE;
                end else begin
                    beat_v_s = 1'b1;
                    beat_wr_s = (state_q == ST_WRITE);
                    col_d = next_col(col_q, mask_q);
                    beats_d = beats_q - 3'd1;
                    if (beats_q == 3'd1) begin
                        state_d = ST_IDLE;
                        if (ap_q) open_d[bbank_q] = 1'b0;
                        else open_d = open_d;
                    end else begin
                        state_d = state_q;
                    end
                end
            end else begin
                state_d = ST_IDLE;
            end
            case (cmd_s)
                CMD_LMR: begin
                    if (sdram_addr[2] == 1'b0 && sdram_addr[6:5] == 2'b01) begin
                        mode_valid_d = 1'b1;
                        cl3_d = sdram_addr[4];
                        case (sdram_addr[1:0])
                            2'b00:   bl_mask_d = 3'd0;
                            2'b01:   bl_mask_d = 3'd1;
                            2'b10:   bl_mask_d = 3'd3;
                            default: bl_mask_d = 3'd7;
                        endcase
                    end else begin
                        err_d[2] = 1'b1;
                    end
                end
                CMD_ACT: begin
                    if (open_q[sdram_bank]) begin
                        err_d[1] = 1'b1;
                    end else begin
                        open_d[sdram_bank] = 1'b1;
                        row_d[sdram_bank] = sdram_addr;
                    end
                end
                CMD_PRE: begin
                    if (sdram_addr[10]) open_d = 4'b0000;
                    else open_d[sdram_bank] = 1'b0;
                end
                CMD_RD, CMD_WR: begin
                    if (rw_ok_s) begin
                        beat_v_s = 1'b1;
                        beat_wr_s = (cmd_s == CMD_WR);
                        beat_bank_s = sdram_bank;
                        beat_col_s = sdram_addr[8:0];
                        beats_d = bl_mask_q;
                        mask_d = bl_mask_q;
                        col_d = next_col(sdram_addr[8:0], bl_mask_q);
                        bbank_d = sdram_bank;
                        ap_d = sdram_addr[10];
                        if (bl_mask_q == 3'd0) begin
                            state_d = ST_IDLE;
                            if (sdram_addr[10]) open_d[sdram_bank] = 1'b0;
                            else open_d = open_d;
                        end else begin
                            state_d = (cmd_s == CMD_WR) ? ST_WRITE : ST_READ;
                        end
                    end else begin
                        err_d[0] = 1'b1;
                    end
                end
                CMD_REF: begin
                    if (|open_q) err_d[1] = 1'b1;
                    else err_d = err_d;
                end
                default: err_d = err_d;
            endcase
        end else begin
            state_d = state_q;
        end
`ifdef SDRAM_RESPONDER_TIMING_CHK_EN
        err_d[3] = err_q[3] | tchk_err_s;
`else
        err_d[3] = 1'b0;
`endif
        mem_idx_s = {beat_bank_s, row_q[beat_bank_s][MEM_ROW_BITS-1:0], beat_col_s};
        mem_we_s  = beat_v_s && beat_wr_s;
        mem_be_s  = ~sdram_dqm;
        if (beat_v_s && !beat_wr_s) begin
            pipe_v_d[0] = 1'b1;
            pipe_data_d[0] = mem[mem_idx_s];
        end else begin
            pipe_v_d[0] = pipe_v_d[0];
        end
    end

    // Backing array: not reset, so contents survive sys_rst.
    always_ff @(posedge sys_clk) begin
        if (mem_we_s && !sys_rst) begin
            if (mem_be_s[0]) mem[mem_idx_s][7:0] <= sdram_dq_in[7:0];
            if (mem_be_s[1]) mem[mem_idx_s][15:8] <= sdram_dq_in[15:8];
        end
    end

    // Control and output registers.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= ST_IDLE;    beats_q <= 3'd0;       mask_q <= 3'd0;
            bl_mask_q <= 3'd0;     col_q <= 9'd0;         bbank_q <= 2'd0;
            ap_q <= 1'b0;          cl3_q <= 1'b1;         mode_valid_q <= 1'b0;
            open_q <= 4'd0;        row_q <= 48'd0;        err_q <= 4'd0;
            pipe_v_q <= 3'd0;      pipe_data_q <= 48'd0;
            dqm1_q <= 2'd0;        dqm2_q <= 2'd0;
            dq_oe_q <= 2'd0;       dq_out_q <= 16'd0;
        end else begin
            state_q <= state_d;    beats_q <= beats_d;    mask_q <= mask_d;
            bl_mask_q <= bl_mask_d; col_q <= col_d;       bbank_q <= bbank_d;
            ap_q <= ap_d;          cl3_q <= cl3_d;        mode_valid_q <= mode_valid_d;
            open_q <= open_d;      row_q <= row_d;        err_q <= err_d;
            pipe_v_q <= pipe_v_d;  pipe_data_q <= pipe_data_d;
            dqm1_q <= dqm1_d;      dqm2_q <= dqm2_d;
            dq_oe_q <= dq_oe_d;    dq_out_q <= dq_out_d;
        end
    end

    assign sdram_dq_out = dq_out_q;
    assign sdram_dq_oe  = dq_oe_q;
    assign mode_valid   = mode_valid_q;
    assign err          = err_q;
endmodule

// File: tb/tb_sdram_responder.sv
// tb_sdram_responder: table-driven directed test of sdram_responder plus hand-written corner sequences.
module tb_sdram_responder;
    localparam logic [3:0] NOP = 4'b0111, ACT = 4'b0011, RD = 4'b0101, WR = 4'b0100;
    localparam logic [3:0] PRE = 4'b0010, REF = 4'b0001, LMR = 4'b0000, BST = 4'b0110;
`ifdef SDRAM_RESPONDER_TIMING_CHK_EN
    localparam logic [3:0] TE = 4'b1000;
`else
    localparam logic [3:0] TE = 4'b0000;
`endif

    logic        sys_clk = 1'b0, sys_rst = 1'b1, sdram_cke = 1'b1;
    logic        sdram_cs_n = 1'b1, sdram_ras_n = 1'b1, sdram_cas_n = 1'b1, sdram_we_n = 1'b1;
    logic [1:0]  sdram_bank = 2'd0, sdram_dqm = 2'd0;
    logic [11:0] sdram_addr = 12'd0;
    logic [15:0] sdram_dq_in = 16'd0;
    logic [15:0] sdram_dq_out;
    logic [1:0]  sdram_dq_oe;
    logic        mode_valid;
    logic [3:0]  err;

    int total = 0;
    int bad = 0;

    sdram_responder dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .sdram_cke(sdram_cke),
        .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n), .sdram_cas_n(sdram_cas_n),
        .sdram_we_n(sdram_we_n), .sdram_bank(sdram_bank), .sdram_addr(sdram_addr),
        .sdram_dqm(sdram_dqm), .sdram_dq_in(sdram_dq_in), .sdram_dq_out(sdram_dq_out),
        .sdram_dq_oe(sdram_dq_oe), .mode_valid(mode_valid), .err(err)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [3:0]  cmd;
        logic [1:0]  bank;
        logic [11:0] addr;
        logic [1:0]  dqm;
        logic [15:0] din;
        logic [1:0]  oe;
        logic [15:0] dout;
        logic [3:0]  err;
        logic        mv;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [3:0] c, input logic [1:0] b, input logic [11:0] a,
                       input logic [1:0] m, input logic [15:0] d, input logic [1:0] oe,
                       input logic [15:0] dout, input logic [3:0] e, input logic mv);
        vec_t v;
        v.cmd = c; v.bank = b; v.addr = a; v.dqm = m; v.din = d;
        v.oe = oe; v.dout = dout; v.err = e; v.mv = mv;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one command and advance past the next rising edge.
    task automatic cyc(input logic [3:0] c, input logic [1:0] b, input logic [11:0] a,
                       input logic [1:0] m, input logic [15:0] d);
        {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = c;
        sdram_bank = b; sdram_addr = a; sdram_dqm = m; sdram_dq_in = d;
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        cyc(NOP, 2'd0, 12'h000, 2'b00, 16'h0000);
        sys_rst = 1'b0;
    endtask

    task automatic chk_dq(input string name, input logic [1:0] oe, input logic [15:0] d);
        chk({name, ".oe"}, {30'd0, sdram_dq_oe}, {30'd0, oe});
        chk({name, ".dq"}, {16'd0, sdram_dq_out}, {16'd0, d});
    endtask

    initial begin
        // ---- main table: expectations are the outputs after the edge that samples the row
        add(LMR, 2'd0, 12'h032, 2'b00, 16'h0000, 2'b00, 16'h0000, 4'h0, 1'b1); // 0
        add(ACT, 2'd1, 12'h005, 2'b00, 16'h0000, 2'b00, 16'h0000, 4'h0, 1'b1);
        add(NOP, 2'd0, 12'h000, 2'b00, 16'h0000, 2'b00, 16'h0000, 4'h0, 1'b1);
        add(WR,  2'd1, 12'h000, 2'b00, 16'hA0A0, 2'b00, 16'h0000, 4'h0, 1'b1);
        add(NOP, 2'd0, 12'h000, 2'b00, 16'hA1A1, 2'b00, 16'h0000, 4'h0, 1'b1);
        add(NOP, 2'd0, 12'h000, 2'b00, 16'hA2A2, 2'b00, 16'h0000, 4'h0, 1'b1);
        add(NOP, 2'd0, 12'h000, 2'b00, 16'hA3A3, 2'b00, 16'h0000, 4'h0, 1'b1);
        add(RD,  2'd1, 12'h000, 2'b00, 16'h0000, 2'b00, 16'h0000, 4'h0, 1'b1); // 7: T
        add(NOP, 2'd0, 12'h000, 2'b00, 16'h0000, 2'b00, 16'h0000, 4'h0, 1'b1);
        add(NOP, 2'd0, 12'h000, 2'b00, 16'h0000, 2'b00, 16'h0000, 4'h0, 1'b1);
        add(NOP, 2'd0, 12'h000, 2'b00, 16'h0000, 2'b11, 16'hA0A0, 4'h0, 1'b1); // T+3
        add(NOP, 2'd0, 12'h000, 2'b00, 16'h0000, 2'b11, 16'hA1A1, 4'h0, 1'b1);
        add(NOP, 2'd0, 12'h000, 2'b00, 16'h0000, 2'b11, 16'hA2A2, 4'h0, 1'b1);
        add(NOP, 2'd0, 12'h000, 2'b00, 16'h0000, 2'b11, 16'hA3A3, 4'h0, 1'b1);
        add(NOP, 2'd0, 12'h000, 2'b00, 16'h0000, 2'b00, 16'h0000, 4'h0, 1'b1); // 14
        add(WR,  2'd1, 12'h004, 2'b00, 16'hC4C4, 2'b00, 16'h0000, 4'h0, 1'b1);
        add(NOP, 2'd0, 12'h000, 2'b00, 16'hC5C5, 2'b00, 16'h0000, 4'h0, 1'b1);
        add(NOP, 2'd0, 12'h000, 2'b00, 16'hC6C6, 2'b00, 16'h0000, 4'h0, 1'b1);
        add(NOP, 2'd0, 12'h000, 2'b00, 16'hC7C7, 2'b00, 16'h0000, 4'h0, 1'b1);
        add(RD,  2'd1, 12'h006, 2'b00, 16'h0000, 2'b00, 16'h0000, 4'h0, 1'b1); // 19: wrap read
        add(NOP, 2'd0, 12'h000, 2'b00, 16'h0000, 2'b00, 16'h0000, 4'h0, 1'b1);
        add(NOP, 2'd0, 12'h000, 2'b00, 16'h0000, 2'b00, 16'h0000, 4'h0, 1'b1);
        add(NOP, 2'd0, 12'h000, 2'b00, 16'h0000, 2'b11, 16'hC6C6, 4'h0, 1'b1);
        add(NOP, 2'd0, 12'h000, 2'b00, 16'h0000, 2'b11, 16'hC7C7, 4'h0, 1'b1);
        add(NOP, 2'd0, 12'h000, 2'b00, 16'h0000, 2'b11, 16'hC4C4, 4'h0, 1'b1);
        add(NOP, 2'd0, 12'h000, 2'b00, 16'h0000, 2'b11, 16'hC5C5, 4'h0, 1'b1);
        add(WR,  2'd1, 12'h008, 2'b00, 16'hFFFF, 2'b00, 16'h0000, 4'h0, 1'b1); // 26
        add(WR,  2'd1, 12'h008, 2'b10, 16'h1234, 2'b00, 16'h0000, 4'h0, 1'b1); // interrupts, masked
        add(NOP, 2'd0, 12'h000, 2'b00, 16'h0909, 2'b00, 16'h0000, 4'h0, 1'b1);
        add(NOP, 2'd0, 12'h000, 2'b00, 16'h0A0A, 2'b00, 16'h0000, 4'h0, 1'b1);
        add(NOP, 2'd0, 12'h000, 2'b00, 16'h0B0B, 2'b00, 16'h0000, 4'h0, 1'b1);
        add(RD,  2'd1, 12'h008, 2'b00, 16'h0000, 2'b00, 16'h0000, 4'h0, 1'b1); // 31
        add(NOP, 2'd0, 12'h000, 2'b00, 16'h0000, 2'b00, 16'h0000, 4'h0, 1'b1);
        add(NOP, 2'd0, 12'h000, 2'b01, 16'h0000, 2'b00, 16'h0000, 4'h0, 1'b1); // read dqm
        add(NOP, 2'd0, 12'h000, 2'b00, 16'h0000, 2'b11, 16'hFF34, 4'h0, 1'b1);
        add(NOP, 2'd0, 12'h000, 2'b00, 16'h0000, 2'b10, 16'h0900, 4'h0, 1'b1);
        add(NOP, 2'd0, 12'h000, 2'b00, 16'h0000, 2'b11, 16'h0A0A, 4'h0, 1'b1);
        add(NOP, 2'd0, 12'h000, 2'b00, 16'h0000, 2'b11, 16'h0B0B, 4'h0, 1'b1);
        add(NOP, 2'd0, 12'h000, 2'b00, 16'h0000, 2'b00, 16'h0000, 4'h0, 1'b1);
        add(RD,  2'd2, 12'h000, 2'b00, 16'h0000, 2'b00, 16'h0000, 4'h1, 1'b1); // 39: closed bank
        add(NOP, 2'd0, 12'h000, 2'b00, 16'h0000, 2'b00, 16'h0000, 4'h1, 1'b1);
        add(NOP, 2'd0, 12'h000, 2'b00, 16'h0000, 2'b00, 16'h0000, 4'h1, 1'b1);
        add(NOP, 2'd0, 12'h000, 2'b00, 16'h0000, 2'b00, 16'h0000, 4'h1, 1'b1);
        add(ACT, 2'd1, 12'h007, 2'b00, 16'h0000, 2'b00, 16'h0000, 4'h3, 1'b1); // 43: already open
        add(NOP, 2'd0, 12'h000, 2'b00, 16'h0000, 2'b00, 16'h0000, 4'h3, 1'b1);
        add(NOP, 2'd0, 12'h000, 2'b00, 16'h0000, 2'b00, 16'h0000, 4'h3, 1'b1);
        add(RD,  2'd1, 12'h000, 2'b00, 16'h0000, 2'b00, 16'h0000, 4'h3, 1'b1); // 46: row 5 kept
        add(NOP, 2'd0, 12'h000, 2'b00, 16'h0000, 2'b00, 16'h0000, 4'h3, 1'b1);
        add(NOP, 2'd0, 12'h000, 2'b00, 16'h0000, 2'b00, 16'h0000, 4'h3, 1'b1);
        add(NOP, 2'd0, 12'h000, 2'b00, 16'h0000, 2'b11, 16'hA0A0, 4'h3, 1'b1);
        add(NOP, 2'd0, 12'h000, 2'b00, 16'h0000, 2'b11, 16'hA1A1, 4'h3, 1'b1);
        add(NOP, 2'd0, 12'h000, 2'b00, 16'h0000, 2'b11, 16'hA2A2, 4'h3, 1'b1);
        add(NOP, 2'd0, 12'h000, 2'b00, 16'h0000, 2'b11, 16'hA3A3, 4'h3, 1'b1);
        add(LMR, 2'd0, 12'h072, 2'b00, 16'h0000, 2'b00, 16'h0000, 4'h7, 1'b1); // 53: illegal CL
        add(PRE, 2'd0, 12'h400, 2'b00, 16'h0000, 2'b00, 16'h0000, 4'h7, 1'b1);
        add(NOP, 2'd0, 12'h000, 2'b00, 16'h0000, 2'b00, 16'h0000, 4'h7, 1'b1);
        add(LMR, 2'd0, 12'h020, 2'b00, 16'h0000, 2'b00, 16'h0000, 4'h7, 1'b1); // 56: CL2 BL1
        add(NOP, 2'd0, 12'h000, 2'b00, 16'h0000, 2'b00, 16'h0000, 4'h7, 1'b1);
        add(ACT, 2'd0, 12'h000, 2'b00, 16'h0000, 2'b00, 16'h0000, 4'h7, 1'b1);
        add(NOP, 2'd0, 12'h000, 2'b00, 16'h0000, 2'b00, 16'h0000, 4'h7, 1'b1);
        add(WR,  2'd0, 12'h003, 2'b00, 16'h3333, 2'b00, 16'h0000, 4'h7, 1'b1);
        add(RD,  2'd0, 12'h403, 2'b00, 16'h0000, 2'b00, 16'h0000, 4'h7, 1'b1); // 61: auto-precharge
        add(NOP, 2'd0, 12'h000, 2'b00, 16'h0000, 2'b00, 16'h0000, 4'h7, 1'b1);
        add(NOP, 2'd0, 12'h000, 2'b00, 16'h0000, 2'b11, 16'h3333, 4'h7, 1'b1);
        add(NOP, 2'd0, 12'h000, 2'b00, 16'h0000, 2'b00, 16'h0000, 4'h7, 1'b1);
        add(RD,  2'd0, 12'h003, 2'b00, 16'h0000, 2'b00, 16'h0000, 4'h7, 1'b1); // 65: bank now closed
        add(NOP, 2'd0, 12'h000, 2'b00, 16'h0000, 2'b00, 16'h0000, 4'h7, 1'b1);
        add(NOP, 2'd0, 12'h000, 2'b00, 16'h0000, 2'b00, 16'h0000, 4'h7, 1'b1);

        // ---- reset state
        sys_rst = 1'b1;
        cyc(NOP, 2'd0, 12'h000, 2'b00, 16'h0000);
        cyc(NOP, 2'd0, 12'h000, 2'b00, 16'h0000);
        sys_rst = 1'b0;
        chk_dq("reset", 2'b00, 16'h0000);
        chk("reset.err", {28'd0, err}, 32'd0);
        chk("reset.mv", {31'd0, mode_valid}, 32'd0);

        foreach (tbl[i]) begin
            cyc(tbl[i].cmd, tbl[i].bank, tbl[i].addr, tbl[i].dqm, tbl[i].din);
            chk_dq($sformatf("vec%0d", i), tbl[i].oe, tbl[i].dout);
            chk($sformatf("vec%0d.err", i), {28'd0, err}, {28'd0, tbl[i].err});
            chk($sformatf("vec%0d.mv", i), {31'd0, mode_valid}, {31'd0, tbl[i].mv});
        end

        // ---- BURST STOP: CL3 BL8 read at T, BST at T+2 -> words at T+3, T+4 only
        do_reset();
        cyc(LMR, 2'd0, 12'h033, 2'b00, 16'h0000);
        cyc(ACT, 2'd3, 12'h001, 2'b00, 16'h0000);
        cyc(NOP, 2'd0, 12'h000, 2'b00, 16'h0000);
        for (int k = 0; k < 8; k++)
            cyc((k == 0) ? WR : NOP, 2'd3, 12'h000, 2'b00, 16'hD000 + 16'(k));
        cyc(NOP, 2'd0, 12'h000, 2'b00, 16'h0000);
        cyc(RD, 2'd3, 12'h000, 2'b00, 16'h0000);
        for (int k = 1; k <= 8; k++) begin
            cyc((k == 2) ? BST : NOP, 2'd0, 12'h000, 2'b00, 16'h0000);
            if (k == 3) chk_dq($sformatf("bst%0d", k), 2'b11, 16'hD000);
            else if (k == 4) chk_dq($sformatf("bst%0d", k), 2'b11, 16'hD001);
            else chk_dq($sformatf("bst%0d", k), 2'b00, 16'h0000);
        end

        // ---- cke low for two cycles freezes fetches and the pipeline; output holds
        cyc(RD, 2'd3, 12'h000, 2'b00, 16'h0000);
        for (int k = 1; k <= 10; k++) begin
            sdram_cke = (k == 4 || k == 5) ? 1'b0 : 1'b1;
            cyc(NOP, 2'd0, 12'h000, 2'b00, 16'h0000);
            if (k < 3) chk_dq($sformatf("cke%0d", k), 2'b00, 16'h0000);
            else if (k <= 5) chk_dq($sformatf("cke%0d", k), 2'b11, 16'hD000);
            else chk_dq($sformatf("cke%0d", k), 2'b11, 16'hD000 + 16'(k - 5));
        end
        sdram_cke = 1'b1;
        for (int k = 0; k < 6; k++) cyc(NOP, 2'd0, 12'h000, 2'b00, 16'h0000);

        // ---- reset mid write burst: two beats land, nothing afterwards
        cyc(WR, 2'd3, 12'h000, 2'b00, 16'hE0E0);
        cyc(NOP, 2'd0, 12'h000, 2'b00, 16'hE1E1);
        sys_rst = 1'b1;
        cyc(NOP, 2'd0, 12'h000, 2'b00, 16'hEEEE);
        sys_rst = 1'b0;
        chk("rst_mid.err", {28'd0, err}, 32'd0);
        chk("rst_mid.mv", {31'd0, mode_valid}, 32'd0);
        for (int k = 0; k < 6; k++) cyc(NOP, 2'd0, 12'h000, 2'b00, 16'hEEEE);
        cyc(LMR, 2'd0, 12'h033, 2'b00, 16'h0000);
        cyc(ACT, 2'd3, 12'h001, 2'b00, 16'h0000);
        cyc(NOP, 2'd0, 12'h000, 2'b00, 16'h0000);
        cyc(RD, 2'd3, 12'h000, 2'b00, 16'h0000);
        for (int k = 1; k <= 10; k++) begin
            cyc(NOP, 2'd0, 12'h000, 2'b00, 16'h0000);
            if (k == 3) chk_dq("rst_rd3", 2'b11, 16'hE0E0);
            else if (k == 4) chk_dq("rst_rd4", 2'b11, 16'hE1E1);
            else if (k >= 5) chk_dq($sformatf("rst_rd%0d", k), 2'b11, 16'hD000 + 16'(k - 3));
            else chk_dq($sformatf("rst_rd%0d", k), 2'b00, 16'h0000);
        end

        // ---- closed bank read and double ACTIVE
        do_reset();
        cyc(LMR, 2'd0, 12'h032, 2'b00, 16'h0000);
        cyc(NOP, 2'd0, 12'h000, 2'b00, 16'h0000);
        cyc(RD, 2'd2, 12'h000, 2'b00, 16'h0000);
        chk("closed.err", {28'd0, err}, 32'd1);
        for (int k = 1; k <= 4; k++) begin
            cyc(NOP, 2'd0, 12'h000, 2'b00, 16'h0000);
            chk_dq($sformatf("closed%0d", k), 2'b00, 16'h0000);
        end
        cyc(ACT, 2'd1, 12'h005, 2'b00, 16'h0000);
        cyc(ACT, 2'd1, 12'h005, 2'b00, 16'h0000);
        chk("dblact.err", {28'd0, err}, 32'd3);

        // ---- READ one cycle after ACTIVE: timing flag (if enabled) and data still returned
        do_reset();
        cyc(LMR, 2'd0, 12'h020, 2'b00, 16'h0000);
        cyc(ACT, 2'd0, 12'h000, 2'b00, 16'h0000);
        cyc(RD, 2'd0, 12'h003, 2'b00, 16'h0000);
        chk("trcd.err", {28'd0, err}, {28'd0, TE});
        cyc(NOP, 2'd0, 12'h000, 2'b00, 16'h0000);
        cyc(NOP, 2'd0, 12'h000, 2'b00, 16'h0000);
        chk_dq("trcd.data", 2'b11, 16'h3333);
        cyc(REF, 2'd0, 12'h000, 2'b00, 16'h0000);
        chk("ref_open.err", {28'd0, err}, {28'd0, TE | 4'b0010});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
